rr_arbiter2: RTL

RR_ARBITER2 -- requirements
Module: rr_arbiter2

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_arbiter2_if.sv | 30 +++
 rtl/rr_arbiter2_hold_counter.sv | 31 +++
 rtl/rr_arbiter2.sv | 116 +++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter:
// FSM state encodings and the encoding of the downstream mux select.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2_if.sv
// Handshake bundle between two requesters and the arbiter. The master side
// raises requests and watches grants; the slave side is the arbiter itself.
interface rr_arbiter2_if;

  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;
  logic sel;
  logic busy;

  modport master (
    output req_a,
    output req_b,
    input  grant_a,
    input  grant_b,
    input  sel,
    input  busy
  );

  modport slave (
    input  req_a,
    input  req_b,
    output grant_a,
    output grant_b,
    output sel,
    output busy
  );

endinterface

// File: rtl/rr_arbiter2_hold_counter.sv
// Saturating hold counter: counts how many consecutive cycles the current
// holder has owned the path. Load wins over increment; clear and reset win
// over both. Only built when HOLD_LIMIT_EN is defined.
module hold_counter #(
  parameter int CNT_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_atMax
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear in idle, restart at 1 on a new grant, saturate at MAX_HOLD
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(1);
    end else if (i_inc && (r_count != CNT_W'(MAX_HOLD))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_atMax = (r_count == CNT_W'(MAX_HOLD));

endmodule

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with registered, state-decoded outputs.
// Optional feature macro: HOLD_LIMIT_EN -- when defined, a holder is preempted
// after MAX_HOLD consecutive cycles if the other side is waiting.
module rr_arbiter2
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter2_if.slave bus
);

  if ((MAX_HOLD < 1) || (MAX_HOLD > 7) || (CNT_W < $clog2(MAX_HOLD + 1))) begin : g_badParams
    $error("rr_arbiter2: MAX_HOLD must be 1..7 and CNT_W wide enough to hold it");
  end

  state_t r_state;
  state_t w_nextState;
  logic   r_lastB;
  logic   r_sel;
  logic   r_grantA;
  logic   r_grantB;
  logic   r_busy;
  logic   w_holdExpired;

`ifdef HOLD_LIMIT_EN
  logic w_load;
  logic w_inc;
  logic w_clear;
  logic w_atMax;

  assign w_load  = (w_nextState != IDLE) && (w_nextState != r_state);
  assign w_inc   = (w_nextState != IDLE) && (w_nextState == r_state);
  assign w_clear = (w_nextState == IDLE);

  hold_counter #(
    .CNT_W   (CNT_W),
    .MAX_HOLD(MAX_HOLD)
  ) u_holdCounter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_inc  (w_inc),
    .i_clear(w_clear),
    .o_atMax(w_atMax)
  );

  assign w_holdExpired = w_atMax;
`else
  assign w_holdExpired = 1'b0;
`endif

  // Next-state: idle ties go to the side not served last; a holder that drops
  // its request (or runs out of hold time) hands straight over to a waiter
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          w_nextState = r_lastB ? GNT_A : GNT_B;
        end else if (bus.req_a) begin
          w_nextState = GNT_A;
        end else if (bus.req_b) begin
          w_nextState = GNT_B;
        end
      end
      GNT_A: begin
        if (!bus.req_a) begin
          w_nextState = bus.req_b ? GNT_B : IDLE;
        end else if (w_holdExpired && bus.req_b) begin
          w_nextState = GNT_B;
        end
      end
      GNT_B: begin
        if (!bus.req_b) begin
          w_nextState = bus.req_a ? GNT_A : IDLE;
        end else if (w_holdExpired && bus.req_a) begin
          w_nextState = GNT_A;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State and output registers; sel and last_b only move on entry to a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grantA <= 1'b0;
      r_grantB <= 1'b0;
      r_busy   <= 1'b0;
      r_sel    <= SEL_A;
      r_lastB  <= 1'b1;
    end else begin
      r_state  <= w_nextState;
      r_grantA <= (w_nextState == GNT_A);
      r_grantB <= (w_nextState == GNT_B);
      r_busy   <= (w_nextState != IDLE);
      if (w_nextState == GNT_A) begin
        r_sel   <= SEL_A;
        r_lastB <= 1'b0;
      end else if (w_nextState == GNT_B) begin
        r_sel   <= SEL_B;
        r_lastB <= 1'b1;
      end
    end
  end

  assign bus.grant_a = r_grantA;
  assign bus.grant_b = r_grantB;
  assign bus.sel     = r_sel;
  assign bus.busy    = r_busy;

endmodule
